// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length and common command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_e;

   // Device clock falling edges in one host-to-device frame, ACK sample included
   localparam int unsigned FRAME_EDGES = 11;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the raw PS/2 lines plus falling-edge detect on the clock line.
module ps2_sync (
   input  logic sys_clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [1:0] clk_meta;
   logic [1:0] data_meta;
   logic       clk_prev;

   // Idle bus level is high, so everything clears to 1
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         clk_meta  <= 2'b11;
         data_meta <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_meta  <= {clk_meta[0], ps2_clk};
         data_meta <= {data_meta[0], ps2_data};
         clk_prev  <= clk_meta[1];
      end
   end

   assign clk_sync  = clk_meta[1];
   assign data_sync = data_meta[1];
   assign clk_fall  = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, parity, stop, ACK sample).
// Optional watchdog on device clocking enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

   ps2_tx_state_e    state;
   ps2_tx_state_e    state_nxt;
   logic             clk_s;
   logic             data_s;
   logic             fall;
   logic             accept;
   logic             inh_last;
   logic             bus_idle;
   logic             timeout;
   logic [7:0]       shift_byte;
   logic             par_bit;
   logic [2:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic             success;

   ps2_sync u_sync (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .clk_sync  (clk_s),
      .data_sync (data_s),
      .clk_fall  (fall)
   );

   assign accept   = tx_valid && (state == ST_IDLE);
   assign inh_last = (state == ST_INHIBIT) && (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
   assign bus_idle = clk_s && data_s;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            watched;

   assign watched = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE};
   // Unwatched states hold the counter at zero, which also restarts it on entry to START
   assign timeout = watched && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst)
         wd_cnt <= '0;
      else if (!watched || fall)
         wd_cnt <= '0;
      else if (!timeout)
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (tx_valid) state_nxt = ST_INHIBIT;
         ST_INHIBIT:   if (inh_last) state_nxt = ST_START;
         ST_START: begin
            if (timeout)   state_nxt = ST_IDLE;
            else if (fall) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (timeout)                     state_nxt = ST_IDLE;
            else if (fall && bit_cnt == 3'd7) state_nxt = ST_PARITY;
         end
         ST_PARITY: begin
            if (timeout)   state_nxt = ST_IDLE;
            else if (fall) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (fall)         state_nxt = data_s ? ST_WAIT_IDLE : ST_ACK;
            else if (timeout) state_nxt = ST_IDLE;
         end
         ST_ACK:       state_nxt = ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (bus_idle || timeout) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_ready    = (state == ST_IDLE);
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_done     = 1'b0;
      tx_err      = 1'b0;
      case (state)
         ST_INHIBIT: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = inh_last;
         end
         ST_START: begin
            ps2_data_oe = 1'b1;
            tx_err      = timeout;
         end
         ST_DATA: begin
            ps2_data_oe = ~shift_byte[bit_cnt];
            tx_err      = timeout;
         end
         ST_PARITY: begin
            ps2_data_oe = ~par_bit;
            tx_err      = timeout;
         end
         ST_STOP:    tx_err = (fall && data_s) || timeout;
         ST_WAIT_IDLE: begin
            if (bus_idle) tx_done = success;
            else          tx_err  = timeout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         inh_cnt <= '0;
         bit_cnt <= '0;
         success <= 1'b0;
      end else begin
         if (accept)
            inh_cnt <= '0;
         else if (state == ST_INHIBIT)
            inh_cnt <= inh_cnt + 1'b1;

         // Index saturates at 7; leaving DATA is what ends the byte
         if (state == ST_START)
            bit_cnt <= '0;
         else if (state == ST_DATA && fall && bit_cnt != 3'd7)
            bit_cnt <= bit_cnt + 1'b1;

         if (accept)
            success <= 1'b0;
         else if (state == ST_ACK)
            success <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (accept) begin
         shift_byte <= tx_data;
         par_bit    <= odd_parity(tx_data);
      end
   end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000; sys_clk cycles the clock line is held low before start (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000; maximum sys_clk cycles between device clock falling edges (20 ms at 50 MHz).
REQ-003 SHALL have port sys_clk  in  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  in  8  command byte to send to keyboard (e.g. 0xED set-LEDs).
REQ-006 SHALL have port tx_valid  in  1  request; byte accepted when tx_valid && tx_ready.
REQ-007 SHALL have port tx_ready  out  1  high only in IDLE.
REQ-008 SHALL have port tx_done  out  1  one-cycle pulse on successful ACK and bus idle.
REQ-009 SHALL have port tx_err  out  1  one-cycle pulse on missing ACK or timeout.
REQ-010 SHALL have ports ps2_clk / ps2_data  in  1 each  raw bus line levels (asynchronous).
REQ-011 SHALL have ports ps2_clk_oe / ps2_data_oe  out  1 each  1 = pull line low; 0 = release (open-drain built at top level).

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; falling edge = previous synced 1, current synced 0.
REQ-013 SHALL implement states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-014 IDLE: both oe low, tx_ready high; on handshake latch tx_data, compute odd parity (~^tx_data), go INHIBIT next cycle.
REQ-015 INHIBIT: ps2_clk_oe high for exactly INHIBIT_CYCLES cycles; ps2_data_oe asserted in final cycle; then START.
REQ-016 START: ps2_clk_oe low, ps2_data_oe high (start bit 0); on 1st device falling edge drive data bit 0, go DATA.
REQ-017 DATA: on each later falling edge drive next bit LSB first (oe = ~bit); after bit 7 driven, next falling edge drives parity, go PARITY.
REQ-018 PARITY: next falling edge releases data (stop bit 1), go STOP.
REQ-019 STOP: next falling edge (11th overall) samples synced data; 0 -> ACK, 1 -> tx_err pulse, go WAIT_IDLE.
REQ-020 ACK: go WAIT_IDLE with success flag set.
REQ-021 WAIT_IDLE: when synced clk and data both high, pulse tx_done (if success), return IDLE; no new byte accepted before.
REQ-022 tx_done and tx_err SHALL never assert in the same cycle and each lasts exactly one cycle.
REQ-023 tx_valid while not tx_ready SHALL be ignored; latched byte SHALL not change mid-frame.
REQ-024 Bit counter SHALL be 3 bits, wraps only via state change; no extra falling edges counted after STOP.

Reset
REQ-025 While rst low: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 after release, tx_done=0, tx_err=0, counters and synchronizers cleared to idle level (1).
REQ-026 Reset mid-frame SHALL release both lines immediately (asynchronously) and discard the byte without tx_err.

Configuration
REQ-027 Macro PS2_TX_TIMEOUT_EN: defined -> watchdog counter restarts on each falling edge and on entry to START; reaching TIMEOUT_CYCLES in START..STOP or WAIT_IDLE releases lines, pulses tx_err, returns IDLE.
REQ-028 Without PS2_TX_TIMEOUT_EN: no watchdog logic; block waits indefinitely for device clocks; TIMEOUT_CYCLES unused.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the state enumeration, the 11-edge frame length constant and common PS/2 command constants (0xED set-LEDs, 0xFF reset, 0xFA ACK byte).
REQ-030 Sub-module ps2_sync SHALL contain the 2-flop synchronizers and falling-edge detect, reusable by the keyboard receiver.

Verification
REQ-031 Send 0xED with device model clocking -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK low -> tx_done one pulse, tx_err 0.
REQ-032 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; both end with tx_done.
REQ-033 Check INHIBIT: ps2_clk_oe high for exactly 5000 cycles, ps2_data_oe rising in last cycle, clk released before first device edge.
REQ-034 Device leaves data high at 11th edge -> tx_err one pulse, no tx_done, return to IDLE after lines idle.
REQ-035 rst low during DATA bit 4 -> both oe 0 same cycle, tx_ready 1 after release, no done/err pulses.
REQ-036 With PS2_TX_TIMEOUT_EN, device stops clocking after 3 edges -> tx_err after TIMEOUT_CYCLES, lines released; without macro, block remains in DATA.
